// File: rtl/sram_port_arbiter.sv
// Round-robin front end for one SRAM port: two valid/ready clients, registered
// memory command, tagged read-return pipeline and a zero-fill clear engine.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_we,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                 rsp_valid,
    output logic [1:0][DATA_WIDTH-1:0] rsp_rdata,
    input  logic                       clear_start,
    output logic                       clear_busy,
    output logic                       clear_done,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_din,
    input  logic [DATA_WIDTH-1:0]      mem_dout
);

    typedef enum logic {
        ST_ARB,
        ST_CLEAR
    } state_t;

    state_t                state_reg;
    logic                  rr_ptr_reg;
    logic [ADDR_WIDTH-1:0] clear_cnt_reg;
    logic                  tag0_valid_reg;
    logic                  tag0_id_reg;
    logic                  tag1_valid_reg;
    logic                  tag1_id_reg;

    logic                  handshake;
    logic                  grant_id;
    logic [1:0]            tag_hit;

    // Clear start has priority: no client is granted in the cycle it is taken.
    always_comb begin
        req_ready = 2'b00;
        if (state_reg == ST_ARB && !clear_start) begin
            if (req_valid == 2'b11) begin
                req_ready[rr_ptr_reg] = 1'b1;
            end else begin
                req_ready = req_valid;
            end
        end
    end

    assign handshake = |req_ready;
    assign grant_id  = req_ready[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit
            assign tag_hit[gi] = tag1_valid_reg && (tag1_id_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_ARB;
            rr_ptr_reg     <= 1'b0;
            clear_cnt_reg  <= '0;
            tag0_valid_reg <= 1'b0;
            tag0_id_reg    <= 1'b0;
            tag1_valid_reg <= 1'b0;
            tag1_id_reg    <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_din        <= '0;
            rsp_valid      <= 2'b00;
            rsp_rdata      <= '0;
            clear_busy     <= 1'b0;
            clear_done     <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            clear_done <= 1'b0;

            // Tag stage 0 lines up with the SRAM sampling the address, stage 1 with dout.
            tag0_valid_reg <= handshake && !req_we[grant_id];
            tag0_id_reg    <= grant_id;
            tag1_valid_reg <= tag0_valid_reg;
            tag1_id_reg    <= tag0_id_reg;

            rsp_valid <= tag_hit;
            for (int i = 0; i < 2; i++) begin
                if (tag_hit[i]) begin
                    rsp_rdata[i] <= mem_dout;
                end
            end

            case (state_reg)
                ST_ARB: begin
                    if (clear_start) begin
                        state_reg     <= ST_CLEAR;
                        clear_cnt_reg <= '0;
                        clear_busy    <= 1'b1;
                    end else if (handshake) begin
                        mem_we     <= req_we[grant_id];
                        mem_addr   <= req_addr[grant_id];
                        mem_din    <= req_wdata[grant_id];
                        rr_ptr_reg <= ~rr_ptr_reg;
                    end
                end
                ST_CLEAR: begin
                    mem_we        <= 1'b1;
                    mem_addr      <= clear_cnt_reg;
                    mem_din       <= '0;
                    clear_cnt_reg <= clear_cnt_reg + 1'b1;
                    if (clear_cnt_reg == '1) begin
                        state_reg  <= ST_ARB;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end
                end
                default: state_reg <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter with an attached SRAM
// model and a transaction-level reference (memory image plus response queue).
module tb_sram_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           req_valid = 2'b00;
    logic [1:0]           req_ready;
    logic [1:0]           req_we = 2'b00;
    logic [1:0][AW-1:0]   req_addr = '0;
    logic [1:0][DW-1:0]   req_wdata = '0;
    logic [1:0]           rsp_valid;
    logic [1:0][DW-1:0]   rsp_rdata;
    logic                 clear_start = 1'b0;
    logic                 clear_busy;
    logic                 clear_done;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_din;
    logic [DW-1:0]        mem_dout;

    logic                 load_en = 1'b0;
    logic [AW-1:0]        load_addr = '0;
    logic [DW-1:0]        load_data = '0;
    logic [DW-1:0]        sram [0:DEPTH-1];

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Read-before-write SRAM port, one cycle read latency.
    always @(posedge clk) begin
        if (load_en) begin
            sram[load_addr] <= load_data;
        end else if (mem_we) begin
            sram[mem_addr] <= mem_din;
        end
        mem_dout <= sram[mem_addr];
    end

    typedef struct {
        int          due;
        int          id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          pending[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_rdata [2];
    logic [1:0]    exp_rsp_valid = 2'b00;
    bit            rr = 1'b0;
    bit            m_clear = 1'b0;
    bit            exp_busy = 1'b0;
    bit            exp_done = 1'b0;
    int            clear_left = 0;
    int            cyc = 0;
    int            pass_cnt = 0;
    int            total_cnt = 0;

    function automatic logic [1:0] model_ready();
        if (m_clear || clear_start) return 2'b00;
        if (req_valid == 2'b11) return rr ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    // Advance one clock and update the reference; returns at the next negedge.
    task automatic tick();
        logic [1:0] r;
        int id;
        rsp_t e;
        r = model_ready();
        @(posedge clk);
        cyc++;
        exp_rsp_valid = 2'b00;
        if (!rst_n) begin
            rr = 1'b0; m_clear = 1'b0; clear_left = 0;
            exp_busy = 1'b0; exp_done = 1'b0;
            exp_rdata[0] = '0; exp_rdata[1] = '0;
            pending.delete();
        end else begin
            exp_done = 1'b0;
            if (m_clear) begin
                ref_mem[DEPTH - clear_left] = '0;
                clear_left--;
                if (clear_left == 0) begin
                    m_clear = 1'b0; exp_busy = 1'b0; exp_done = 1'b1;
                end
            end else if (clear_start) begin
                m_clear = 1'b1; clear_left = DEPTH; exp_busy = 1'b1;
            end else if (r != 2'b00) begin
                id = r[1] ? 1 : 0;
                if (req_we[id]) begin
                    ref_mem[req_addr[id]] = req_wdata[id];
                end else begin
                    e.due = cyc + 2; e.id = id; e.data = ref_mem[req_addr[id]];
                    pending.push_back(e);
                end
                $display("txn cyc=%0d client=%0d %s addr=%h wdata=%h", cyc, id,
                         req_we[id] ? "WR" : "RD", req_addr[id], req_wdata[id]);
                rr = ~rr;
            end
            while (pending.size() > 0 && pending[0].due == cyc) begin
                e = pending.pop_front();
                exp_rsp_valid[e.id] = 1'b1;
                exp_rdata[e.id] = e.data;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        req_valid = 2'b00;
        clear_start = 1'b0;
    endtask

    task automatic set_req(input int c, input bit we, input int addr, input logic [DW-1:0] d);
        req_valid[c] = 1'b1;
        req_we[c]    = we;
        req_addr[c]  = addr[AW-1:0];
        req_wdata[c] = d;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        total_cnt++; if ({mem_we, mem_addr, mem_din} !== '0) $display("FAIL reset_mem got we=%b addr=%h din=%h want 0", mem_we, mem_addr, mem_din); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 2'b00 || rsp_rdata !== '0) $display("FAIL reset_rsp got v=%b d=%h want 0", rsp_valid, rsp_rdata); else pass_cnt++;
        total_cnt++; if ({clear_busy, clear_done} !== 2'b00) $display("FAIL reset_clear got %b want 00", {clear_busy, clear_done}); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 2'b00) $display("FAIL reset_ready got %b want 00", req_ready); else pass_cnt++;
    endtask

    task automatic test_write_read();
        set_idle();
        set_req(0, 1'b1, 5, 32'hDEADBEEF);
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL wr_ready got %b want 01", req_ready); else pass_cnt++;
        tick();
        set_idle();
        set_req(0, 1'b0, 5, '0);
        #1;
        total_cnt++; if (req_ready !== model_ready()) $display("FAIL rd_ready got %b want %b", req_ready, model_ready()); else pass_cnt++;
        tick();
        set_idle();
        tick();
        total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL rd_early got %b want 00", rsp_valid); else pass_cnt++;
        tick();
        total_cnt++; if (rsp_valid !== 2'b01) $display("FAIL rd_valid got %b want 01", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_rdata[0] !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", rsp_rdata[0]); else pass_cnt++;
        tick();
        total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL rd_pulse got %b want 00", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_alternate();
        logic [1:0] want;
        for (int k = 0; k < 9; k++) begin
            set_idle();
            if (k < 6) begin
                set_req(0, 1'b0, 1, '0);
                set_req(1, 1'b0, 2, '0);
            end
            #1;
            want = (k >= 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            total_cnt++; if (req_ready !== want) $display("FAIL alt_ready k=%0d got %b want %b", k, req_ready, want); else pass_cnt++;
            tick();
            total_cnt++; if (rsp_valid !== exp_rsp_valid) $display("FAIL alt_rsp k=%0d got %b want %b", k, rsp_valid, exp_rsp_valid); else pass_cnt++;
            for (int c = 0; c < 2; c++) begin
                if (exp_rsp_valid[c]) begin
                    total_cnt++; if (rsp_rdata[c] !== exp_rdata[c]) $display("FAIL alt_data c=%0d got %h want %h", c, rsp_rdata[c], exp_rdata[c]); else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_single_client();
        logic [1:0] want;
        for (int k = 0; k < 7; k++) begin
            set_idle();
            if (k < 5) set_req(1, 1'b0, 2, '0);
            if (k == 4) set_req(0, 1'b0, 1, '0);
            #1;
            want = (k < 4) ? 2'b10 : ((k == 4) ? 2'b01 : 2'b00);
            total_cnt++; if (req_ready !== want) $display("FAIL single_ready k=%0d got %b want %b", k, req_ready, want); else pass_cnt++;
            tick();
            total_cnt++; if (rsp_valid !== exp_rsp_valid) $display("FAIL single_rsp k=%0d got %b want %b", k, rsp_valid, exp_rsp_valid); else pass_cnt++;
            for (int c = 0; c < 2; c++) begin
                if (exp_rsp_valid[c]) begin
                    total_cnt++; if (rsp_rdata[c] !== exp_rdata[c]) $display("FAIL single_data c=%0d got %h want %h", c, rsp_rdata[c], exp_rdata[c]); else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] want;
        for (int k = 0; k < 400; k++) begin
            set_idle();
            if (k < 396) begin
                req_valid = 2'($urandom_range(0, 3));
                for (int c = 0; c < 2; c++) begin
                    req_we[c]    = 1'($urandom_range(0, 1));
                    req_addr[c]  = AW'($urandom_range(0, 15));
                    req_wdata[c] = $urandom;
                end
            end
            #1;
            want = model_ready();
            total_cnt++; if (req_ready !== want) $display("FAIL rand_ready k=%0d got %b want %b", k, req_ready, want); else pass_cnt++;
            tick();
            total_cnt++; if (rsp_valid !== exp_rsp_valid) $display("FAIL rand_rsp k=%0d got %b want %b", k, rsp_valid, exp_rsp_valid); else pass_cnt++;
            for (int c = 0; c < 2; c++) begin
                if (exp_rsp_valid[c]) begin
                    total_cnt++; if (rsp_rdata[c] !== exp_rdata[c]) $display("FAIL rand_data k=%0d c=%0d got %h want %h", k, c, rsp_rdata[c], exp_rdata[c]); else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        set_idle();
        set_req(1, 1'b1, 'h3FF, 32'h1234);
        tick();
        for (int k = 0; k < 1030; k++) begin
            set_idle();
            if (k == 0) begin
                clear_start = 1'b1;
                set_req(0, 1'b0, 3, '0);
            end
            if (k == 300) begin
                set_req(0, 1'b0, 3, '0);
                set_req(1, 1'b1, 4, 32'h55);
            end
            if (k == 500) clear_start = 1'b1;
            #1;
            total_cnt++; if (req_ready !== model_ready()) $display("FAIL clr_ready k=%0d got %b want %b", k, req_ready, model_ready()); else pass_cnt++;
            tick();
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
            total_cnt++; if ({clear_busy, clear_done} !== {exp_busy, exp_done}) $display("FAIL clr_state k=%0d got busy/done=%b want %b", k, {clear_busy, clear_done}, {exp_busy, exp_done}); else pass_cnt++;
        end
        total_cnt++; if (busy_cnt != DEPTH) $display("FAIL clr_busy_len got %0d want %0d", busy_cnt, DEPTH); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL clr_done_cnt got %0d want 1", done_cnt); else pass_cnt++;
        set_idle();
        set_req(0, 1'b0, 'h3FF, '0);
        tick();
        set_idle();
        tick();
        tick();
        total_cnt++; if (rsp_valid !== 2'b01 || rsp_rdata[0] !== '0) $display("FAIL clr_readback got v=%b d=%h want v=01 d=0", rsp_valid, rsp_rdata[0]); else pass_cnt++;
    endtask

    task automatic test_inflight_clear();
        int busy_cnt = 0;
        int got_a5 = 0;
        set_idle();
        set_req(0, 1'b1, 7, 32'hA5);
        tick();
        set_idle();
        set_req(0, 1'b0, 7, '0);
        tick();
        for (int k = 0; k < 1030; k++) begin
            set_idle();
            if (k == 0 || k == 400) clear_start = 1'b1;
            #1;
            tick();
            if (clear_busy) busy_cnt++;
            if (rsp_valid[0] && rsp_rdata[0] === 32'hA5) got_a5++;
            total_cnt++; if (rsp_valid !== exp_rsp_valid) $display("FAIL infl_rsp k=%0d got %b want %b", k, rsp_valid, exp_rsp_valid); else pass_cnt++;
            total_cnt++; if ({clear_busy, clear_done} !== {exp_busy, exp_done}) $display("FAIL infl_state k=%0d got %b want %b", k, {clear_busy, clear_done}, {exp_busy, exp_done}); else pass_cnt++;
        end
        total_cnt++; if (got_a5 != 1) $display("FAIL infl_data got %0d responses of a5 want 1", got_a5); else pass_cnt++;
        total_cnt++; if (busy_cnt != DEPTH) $display("FAIL infl_busy_len got %0d want %0d", busy_cnt, DEPTH); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit any_rsp = 1'b0;
        bit any_done = 1'b0;
        bit any_busy = 1'b0;
        set_idle();
        set_req(0, 1'b0, 1, '0);
        tick();
        set_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++; if ({mem_we, mem_addr, mem_din, rsp_valid, rsp_rdata, clear_busy, clear_done} !== '0) $display("FAIL rstmid_vals got we=%b addr=%h din=%h rv=%b busy=%b done=%b want 0", mem_we, mem_addr, mem_din, rsp_valid, clear_busy, clear_done); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            any_rsp |= |rsp_valid;
        end
        total_cnt++; if (any_rsp) $display("FAIL rstmid_rsp got a response want none"); else pass_cnt++;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (100) tick();
        total_cnt++; if (clear_busy !== 1'b1) $display("FAIL rstclr_busy got %b want 1", clear_busy); else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++; if ({mem_we, mem_addr, mem_din, rsp_valid, clear_busy, clear_done} !== '0) $display("FAIL rstclr_vals got we=%b addr=%h din=%h busy=%b done=%b want 0", mem_we, mem_addr, mem_din, clear_busy, clear_done); else pass_cnt++;
        for (int k = 0; k < 1100; k++) begin
            tick();
            any_done |= clear_done;
            any_busy |= clear_busy;
        end
        total_cnt++; if (any_done || any_busy) $display("FAIL rstclr_abort got done=%b busy=%b want 0 0", any_done, any_busy); else pass_cnt++;
        set_idle();
        set_req(1, 1'b0, 2, '0);
        set_req(0, 1'b0, 1, '0);
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL rstclr_rr got %b want 01", req_ready); else pass_cnt++;
        tick();
        set_idle();
        tick();
        tick();
        total_cnt++; if (rsp_valid !== exp_rsp_valid || rsp_rdata[0] !== exp_rdata[0]) $display("FAIL rstclr_read got v=%b d=%h want v=%b d=%h", rsp_valid, rsp_rdata[0], exp_rsp_valid, exp_rdata[0]); else pass_cnt++;
    endtask

    initial begin
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        load_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            load_addr = AW'(i);
            load_data = $urandom;
            ref_mem[i] = load_data;
            @(negedge clk);
        end
        load_en = 1'b0;
        test_reset();
        test_write_read();
        test_alternate();
        test_single_client();
        test_random();
        test_clear();
        test_inflight_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Single-clock front end for one port of the team's dual-port SRAM. It arbitrates two valid/ready request clients round-robin onto that port's `we`/`addr`/`din`, captures the registered read data and routes it back to the issuing client. It also contains a clear engine that zero-fills the whole memory on command. The block sits directly upstream of the SRAM port and shares its clock.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 10, address width; `MEM_DEPTH = 1 << ADDR_WIDTH`

Ports:
- `clk`  in  1  single clock; the SRAM port is also clocked by `clk`
- `rst_n`  in  1  reset, synchronous and active-low
- `req_valid[i]`, i=0,1  in  1  client i request valid
- `req_ready[i]`  out  1  client i request accepted this cycle
- `req_we[i]`  in  1  1 = write, 0 = read
- `req_addr[i]`  in  ADDR_WIDTH  request address
- `req_wdata[i]`  in  DATA_WIDTH  write data
- `rsp_valid[i]`  out  1  one-cycle pulse; read data for client i
- `rsp_rdata[i]`  out  DATA_WIDTH  read data, valid with `rsp_valid[i]`
- `clear_start`  in  1  pulse; begins a zero-fill of the memory
- `clear_busy`  out  1  clear engine active
- `clear_done`  out  1  one-cycle pulse after the last clear write
- `mem_we`  out  1  to SRAM port `we` (registered)
- `mem_addr`  out  ADDR_WIDTH  to SRAM port `addr` (registered)
- `mem_din`  out  DATA_WIDTH  to SRAM port `din` (registered)
- `mem_dout`  in  DATA_WIDTH  from SRAM port `dout`; valid one cycle after the address edge

## Operation
- States:
  - ARB (reset state).
  - CLEAR.
- ARB:
  - A handshake occurs when `req_valid[i] && req_ready[i]`.
  - At most one client is granted per cycle. `req_ready` is combinational from `req_valid`, the state and `rr_ptr`.
  - If both clients are valid, client `rr_ptr` wins.
  - After any handshake, `rr_ptr` moves to the other client. With no handshake, `rr_ptr` holds.
  - If only one client is valid, it is granted regardless of `rr_ptr`.
- On a handshake the request is registered onto `mem_*`:
  - `mem_we` = `req_we`.
  - `mem_addr` = `req_addr`.
  - `mem_din` = `req_wdata`.
- With no handshake, `mem_we` is 0, and `mem_addr`/`mem_din` hold their previous values.
- Reads carry a {valid, client id} tag through two pipeline stages, aligned with SRAM read latency. Writes produce no response.
- Taking `clear_start` in ARB:
  - Next state is CLEAR; the address counter is set to 0.
  - Both `req_ready` are 0 in the same cycle as `clear_start`: clear wins and there is no handshake.
- CLEAR:
  - Every cycle the block issues `mem_we=1`, `mem_din=0`, `mem_addr=counter`, then increments the counter.
  - Both `req_ready` are 0 throughout.
  - After issuing address `MEM_DEPTH-1`, the block returns to ARB and pulses `clear_done` for one cycle (the cycle after that write is issued). The counter then wraps to 0; nothing else happens on the wrap.
- `clear_start` is ignored while in CLEAR (no restart).
- Reads already in flight when CLEAR begins complete normally and return data read before the clear write to their address.
- `rr_ptr` is unchanged by a clear.
- Port ordering: the SRAM sees requests strictly in handshake order. A read issued after a write to the same address returns the new data.

## Timing
- Reset values (synchronous, `rst_n=0` sampled at an edge):
  - `mem_we=0`, `mem_addr=0`, `mem_din=0`.
  - `rsp_valid=0`, `rsp_rdata=0`.
  - `clear_busy=0`, `clear_done=0`.
  - `rr_ptr=0`, state=ARB, pipeline tags cleared.
- Reset mid-operation discards in-flight reads (no `rsp_valid`) and aborts a clear (no `clear_done`).
- Read latency, with the handshake at edge E0:
  - `mem_addr` is valid after E0.
  - The SRAM samples at E1; `mem_dout` is valid after E1.
  - `rsp_rdata`/`rsp_valid` are registered at E2 and high for exactly the cycle after E2.
  - Total: 2 cycles from the handshake edge.
- Throughput: one request per cycle sustained; back-to-back reads give back-to-back responses.
- Write: SRAM updated at E1.
- `clear_busy`:
  - Goes 1 the cycle after `clear_start` is taken.
  - Is 1 for exactly `MEM_DEPTH` cycles.
  - Falls in the same cycle `clear_done` pulses.
- The first client handshake is possible in the cycle `clear_done` is high.
- Full clear: `MEM_DEPTH` cycles, i.e. 1024 at defaults.

## Test plan
- Reset, then client 0 writes 0xDEADBEEF to addr 5, then reads addr 5 → `rsp_valid[0]` pulses 2 cycles after the read handshake with `rsp_rdata[0]=0xDEADBEEF`; `rsp_valid[1]` stays 0.
- Both clients hold `req_valid` with reads to 1 and 2 for 6 cycles → grants alternate 0,1,0,1,0,1; responses alternate with the matching data; no gaps.
- Only client 1 valid for 4 cycles while `rr_ptr=0` → 4 consecutive grants to client 1, and `rr_ptr` toggles after each.
- Write 0x1234 to addr 0x3FF; pulse `clear_start` alongside a client read request → no handshake that cycle; `clear_busy` high 1024 cycles; `clear_done` one pulse; a subsequent read of addr 0x3FF returns 0.
- Issue a read of addr 7 (holding 0xA5), then `clear_start` next cycle → the read still returns 0xA5; a second `clear_start` mid-clear does not extend `clear_busy`.
- Assert `rst_n=0` one cycle after a read handshake and mid-clear → no `rsp_valid` and no `clear_done` appear; all outputs read reset values the cycle after reset.
